// File: rtl/speed_sequencer_if.sv
// speed_sequencer_if: control, speed handshake and display bus of the speed sequencer
interface speed_sequencer_if;
    logic       Start;
    logic       Stop;
    logic       SpeedReq;
    logic [1:0] SpeedIn;
    logic       SpeedAck;
    logic [1:0] Speed;
    logic       Enable;
    logic [3:0] CounterValue;
    logic       Running;
    logic       Wrap;

    modport master (
        output Start, Stop, SpeedReq, SpeedIn,
        input  SpeedAck, Speed, Enable, CounterValue, Running, Wrap
    );

    modport slave (
        input  Start, Stop, SpeedReq, SpeedIn,
        output SpeedAck, Speed, Enable, CounterValue, Running, Wrap
    );
endinterface

// File: rtl/speed_sequencer.sv
// speed_sequencer: run/pause/stop controller owning the rate divider, display counter and speed handshake
// Optional feature: define SPEED_SEQ_AUTOSTOP_EN to stop in IDLE holding COUNT_MAX instead of wrapping to 0.
module speed_sequencer #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int COUNT_MAX       = 15
) (
    input  logic             ClockIn,
    input  logic             Reset,
    speed_sequencer_if.slave bus
);
    localparam int DW = $clog2(4 * CLOCK_FREQUENCY) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [3:0]    cnt_q;
    logic [1:0]    speed_q;
    logic          ack_q;
    logic          wrap_q;
    logic          serve;
    logic          enable;
    logic          at_max;
    logic          go;
    logic [1:0]    speed_d;
    logic [DW-1:0] reload_d;

    function automatic logic [DW-1:0] reload(input logic [1:0] s);
        return s == 2'b00 ? '0 :
               s == 2'b01 ? DW'(CLOCK_FREQUENCY - 1) :
               s == 2'b10 ? DW'(2 * CLOCK_FREQUENCY - 1) :
                            DW'(4 * CLOCK_FREQUENCY - 1);
    endfunction

    // a request showing its ack is ignored for that cycle; Stop suppresses the tick
    always_comb begin
        serve    = bus.SpeedReq && !ack_q;
        speed_d  = serve ? bus.SpeedIn : speed_q;
        reload_d = reload(speed_d);
        go       = bus.Start && !bus.Stop;
        enable   = state_q == RUN && div_q == '0 && !bus.Stop;
        at_max   = cnt_q == 4'(COUNT_MAX);
    end

    // single-process FSM: state, divider, count, speed and registered pulses
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            speed_q <= '0;
            ack_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    speed_q <= speed_d;
                    ack_q   <= serve;
                    if (serve || go)
                        div_q <= reload_d;
                    if (go) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (bus.Stop) begin
                        state_q <= PAUSE;
                    end else if (enable) begin
                        speed_q <= speed_d;
                        ack_q   <= serve;
                        div_q   <= reload_d;
                        if (at_max) begin
                            wrap_q <= 1'b1;
`ifdef SPEED_SEQ_AUTOSTOP_EN
                            state_q <= IDLE;
`else
                            cnt_q <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        div_q <= div_q - DW'(1);
                    end
                end
                PAUSE: begin
                    speed_q <= speed_d;
                    ack_q   <= serve;
                    if (serve)
                        div_q <= reload_d;
                    if (bus.Stop) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        div_q   <= '0;
                    end else if (bus.Start) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.SpeedAck     = ack_q;
    assign bus.Speed        = speed_q;
    assign bus.Enable       = enable;
    assign bus.CounterValue = cnt_q;
    assign bus.Running      = state_q == RUN;
    assign bus.Wrap         = wrap_q;
endmodule
